// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC shift-add engine driven by an external dual-rail direction unit.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales x/y by ~0.609.
module cordic_iter_engine #(
    parameter int W     = 8,
    parameter int ZW    = 8,
    parameter int ITERS = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    input  logic [W-1:0]  y_in,
    input  logic [ZW-1:0] z_in,
    input  logic          v_in,
    output logic [ITERS-1:0] a,
    output logic          v,
    input  logic          d,
    input  logic          dn,
    output logic [W-1:0]  xo,
    output logic [W-1:0]  yo,
    output logic [ZW-1:0] zo,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err
);

    localparam int IW = 4;
    localparam logic [IW-1:0] LAST = IW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
`ifdef CORDIC_GAIN_COMP_EN
        COMP,
`endif
        DONE
    } state_t;

    state_t state, state_n;

    logic signed [W-1:0]  x_r, y_r, x_n, y_n;
    logic signed [ZW-1:0] z_r, z_n;
    logic                 v_r, v_n, err_r, err_n;
    logic [IW-1:0]        i_r, i_n;

    logic signed [W-1:0]  xs, ys;
    logic signed [ZW-1:0] t;

    // round(atan(2^-i) * 64) in Q2.6
    function automatic logic signed [ZW-1:0] atan_tab(input logic [IW-1:0] k);
        case (k)
            4'd0:    atan_tab = ZW'(50);
            4'd1:    atan_tab = ZW'(30);
            4'd2:    atan_tab = ZW'(16);
            4'd3:    atan_tab = ZW'(8);
            4'd4:    atan_tab = ZW'(4);
            4'd5:    atan_tab = ZW'(2);
            4'd6:    atan_tab = ZW'(1);
            default: atan_tab = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            v_r   <= 1'b0;
            err_r <= 1'b0;
            i_r   <= '0;
        end else begin
            state <= state_n;
            x_r   <= x_n;
            y_r   <= y_n;
            z_r   <= z_n;
            v_r   <= v_n;
            err_r <= err_n;
            i_r   <= i_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x_r;
        y_n     = y_r;
        z_n     = z_r;
        v_n     = v_r;
        err_n   = err_r;
        i_n     = i_r;
        xs      = x_r >>> i_r;
        ys      = y_r >>> i_r;
        t       = atan_tab(i_r);
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    x_n     = $signed(x_in);
                    y_n     = $signed(y_in);
                    z_n     = $signed(z_in);
                    v_n     = v_in;
                    err_n   = 1'b0;
                    i_n     = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (d && dn) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (d || dn) begin
                    // both rails read the pre-step x/y
                    if (d) begin
                        x_n = x_r - ys;
                        y_n = y_r + xs;
                        z_n = z_r - t;
                    end else begin
                        x_n = x_r + ys;
                        y_n = y_r - xs;
                        z_n = z_r + t;
                    end
                    if (i_r == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_n = COMP;
`else
                        state_n = DONE;
`endif
                    end else begin
                        i_n = i_r + 1'b1;
                    end
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                x_n     = (x_r >>> 1) + (x_r >>> 3) - (x_r >>> 6);
                y_n     = (y_r >>> 1) + (y_r >>> 3) - (y_r >>> 6);
                state_n = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign a         = (state == RUN) ? (ITERS'(1) << i_r) : '0;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign v         = v_r;
    assign err       = err_r;
    assign xo        = x_r;
    assign yo        = y_r;
    assign zo        = z_r;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Vector-table bench for cordic_iter_engine with a result scoreboard.
// Expected values switch on CORDIC_GAIN_COMP_EN.
module tb_cordic_iter_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x_in = '0, y_in = '0, z_in = '0;
    logic       v_in = 1'b0;
    logic [4:0] a;
    logic       v;
    logic       d = 1'b0, dn = 1'b0;
    logic [7:0] xo, yo, zo;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;

    int total = 0;
    int bad   = 0;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    typedef struct {
        int x, y, z;
        int ex, ey, ez;
    } res_t;

    typedef struct {
        int         x, y, z;
        logic       vm;
        logic [4:0] pat;
        int         st_it, st_n;
        int         ex, ey, ez;
    } vec_t;

    res_t sb[$];
    vec_t vt[4];

    cordic_iter_engine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .v_in(v_in),
        .a(a), .v(v), .d(d), .dn(dn),
        .xo(xo), .yo(yo), .zo(zo),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input int bp);
        int   cyc, it, st;
        logic hold;
        int   px, py, pz;
        res_t r, e;
        @(negedge clk);
        x_in = 8'(t.x); y_in = 8'(t.y); z_in = 8'(t.z); v_in = t.vm;
        in_valid = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        r.x = t.x; r.y = t.y; r.z = t.z;
        r.ex = t.ex; r.ey = t.ey; r.ez = t.ez;
        sb.push_back(r);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; it = 0; st = 0; hold = 1'b0;
        px = 0; py = 0; pz = 0;
        chk("v_latch", int'(v), int'(t.vm));
        chk("err_clear", int'(err), 0);
        while (!out_valid && cyc < 60) begin
            if (hold) begin
                chk("stall_x", int'($signed(xo)), px);
                chk("stall_y", int'($signed(yo)), py);
                chk("stall_z", int'($signed(zo)), pz);
            end
            chk("a_phase", int'(a), (it < 5) ? (1 << it) : 0);
            hold = 1'b0;
            if (it < 5 && it == t.st_it && st < t.st_n) begin
                d = 1'b0; dn = 1'b0; st++;
                hold = 1'b1;
                px = int'($signed(xo)); py = int'($signed(yo)); pz = int'($signed(zo));
            end else if (it < 5) begin
                d = t.pat[it]; dn = !t.pat[it]; it++;
            end else begin
                d = 1'b0; dn = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        d = 1'b0; dn = 1'b0;
        chk("latency", cyc, LAT + t.st_n);
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        for (int k = 0; k < bp; k++) begin
            px = int'($signed(xo)); py = int'($signed(yo)); pz = int'($signed(zo));
            @(negedge clk);
            chk("bp_x", int'($signed(xo)), px);
            chk("bp_y", int'($signed(yo)), py);
            chk("bp_z", int'($signed(zo)), pz);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("res_x", int'($signed(xo)), e.ex);
            chk("res_y", int'($signed(yo)), e.ey);
            chk("res_z", int'($signed(zo)), e.ez);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after", int'(in_ready), 1);
        chk("valid_drop", int'(out_valid), 0);
    endtask

    initial begin
`ifdef CORDIC_GAIN_COMP_EN
        vt[0] = '{64, 0, 0, 1'b0, 5'b10101, 9, 0, 56, 31, -32};
        vt[1] = '{64, 0, 0, 1'b0, 5'b10101, 2, 3, 56, 31, -32};
        vt[2] = '{0, 64, 0, 1'b0, 5'b00000, 9, 0, 64, -7, 108};
        vt[3] = '{127, 127, 0, 1'b1, 5'b11111, 9, 0, 2, -1, -108};
`else
        vt[0] = '{64, 0, 0, 1'b0, 5'b10101, 9, 0, 93, 50, -32};
        vt[1] = '{64, 0, 0, 1'b0, 5'b10101, 2, 3, 93, 50, -32};
        vt[2] = '{0, 64, 0, 1'b0, 5'b00000, 9, 0, 104, -11, 108};
        vt[3] = '{127, 127, 0, 1'b1, 5'b11111, 9, 0, 4, -2, -108};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_a", int'(a), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_xyz", int'({xo, yo, zo}), 0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++)
            run_vec(vt[k], (k == 2) ? 4 : 0);

        // dual-rail violation on iteration 1
        @(negedge clk);
        x_in = 8'd64; y_in = 8'd0; z_in = 8'd0; v_in = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        d = 1'b1; dn = 1'b0;
        @(negedge clk);
        chk("viol_a1", int'(a), 2);
        d = 1'b1; dn = 1'b1;
        @(negedge clk);
        d = 1'b0; dn = 1'b0;
        chk("viol_err", int'(err), 1);
        chk("viol_a", int'(a), 0);
        chk("viol_in_ready", int'(in_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("viol_no_valid", int'(out_valid), 0);
        end
        chk("viol_sticky", int'(err), 1);
        run_vec(vt[0], 0);

        // reset in the middle of an operation
        @(negedge clk);
        x_in = 8'd64; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        d = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_a", int'(a), 0);
        chk("mid_rst_xo", int'(xo), 0);
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_no_valid", int'(out_valid), 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
